// File: rtl/ed25519_pubkey_reader.sv
// ---------------------------------------------------------------------------
// ed25519_pubkey_reader
//
// Receives the one-cycle valid/public-key pulse from the Ed25519 key
// generator and serializes the key as WORD_W-bit words, most significant
// word first, over a valid/ready stream. A result that arrives while a frame
// is still draining is dropped and flagged through the sticky overrun bit.
// The only exception is a result that coincides with the final-word
// handshake: it starts the next frame with no bubble.
//
// Build option:
//   ED25519_RDR_LE_BYTES_EN - byte-reverse the key on capture so the words
//                             carry the little-endian byte encoding of the key.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     one-cycle result strobe
//   in_data      DATA_W-bit public key, sampled with in_valid
//   out_valid    word available on out_data
//   out_data     current WORD_W-bit word
//   out_last     final word of a frame
//   out_ready    consumer accepts the word when out_valid && out_ready
//   busy         a frame is in progress
//   overrun      sticky flag, set when a result was dropped
//   clr_overrun  clears overrun (a same-cycle drop takes priority)
//   frame_count  number of completed frames, wraps to 0
// ---------------------------------------------------------------------------
module ed25519_pubkey_reader #(
  parameter int DATA_W = 256,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int NUM_WORDS = DATA_W / WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_frame_count;
  // Holds the words not yet presented, next one in the top WORD_W bits.
  logic [DATA_W-1:0]   r_shift;

  logic [DATA_W-1:0]   w_key;
  logic                w_hs;
  logic                w_final;
  logic                w_capture;
  logic                w_advance;
  logic                w_drop;
  logic [IDX_W-1:0]    w_idx_nxt;

`ifdef ED25519_RDR_LE_BYTES_EN
  // Byte 0 <-> byte DATA_W/8-1, so original byte 0 ends up in the top byte.
  function automatic logic [DATA_W-1:0] f_byte_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

  assign w_key = f_byte_rev(in_data);
`else
  assign w_key = in_data;
`endif

  // out_valid is only ever high in SEND, so it alone qualifies the handshake.
  assign w_hs      = r_out_valid && out_ready;
  assign w_final   = w_hs && (r_idx == LAST_IDX);
  assign w_advance = w_hs && (r_idx != LAST_IDX);
  // A strobe is accepted when idle or exactly on the final-word handshake.
  assign w_capture = in_valid && ((r_state == IDLE) || w_final);
  assign w_drop    = in_valid && (r_state == SEND) && !w_final;
  assign w_idx_nxt = r_idx + 1'b1;

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_final) begin
        r_frame_count <= r_frame_count + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_state     <= SEND;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_key[DATA_W-1 -: WORD_W];
            r_out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (w_capture) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_key[DATA_W-1 -: WORD_W];
            r_out_last  <= 1'b0;
          end else if (w_final) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
          end else if (w_advance) begin
            r_idx       <= w_idx_nxt;
            r_out_data  <= r_shift[DATA_W-1 -: WORD_W];
            r_out_last  <= (w_idx_nxt == LAST_IDX);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Key shift register: data only, its contents are don't-care while idle
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_shift <= w_key << WORD_W;
    end else if (w_advance) begin
      r_shift <= r_shift << WORD_W;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = (r_state == SEND);
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ed25519_pubkey_reader.sv
// ---------------------------------------------------------------------------
// tb_ed25519_pubkey_reader
//
// Scoreboard bench for ed25519_pubkey_reader (default 256/32/8 configuration).
// Expected words are queued when a key is driven and are popped by a monitor
// on every handshake. Also tracks stall stability, back-to-back frames,
// overrun handling, mid-frame reset and frame counter wrap.
// ---------------------------------------------------------------------------
module tb_ed25519_pubkey_reader;

  localparam int DATA_W = 256;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [255:0] K_BASIC =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K_ONES = {256{1'b1}};
`ifdef ED25519_RDR_LE_BYTES_EN
  localparam logic [31:0] W0_BASIC = 32'h1F1E1D1C;
`else
  localparam logic [31:0] W0_BASIC = 32'h00010203;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              clr_overrun = 1'b0;
  logic [CNT_W-1:0]  frame_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_hs     = 0;
  int          rdy_mode = 0;
  logic [32:0] sb[$];

  logic        stalled = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  ed25519_pubkey_reader #(
    .DATA_W(DATA_W),
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference word k of a key, independent of the DUT's shift mechanism.
  function automatic logic [31:0] exp_word(input logic [255:0] key, input int k);
    logic [255:0] kk;
`ifdef ED25519_RDR_LE_BYTES_EN
    for (int i = 0; i < 32; i++) kk[8*i +: 8] = key[8*(31-i) +: 8];
`else
    kk = key;
`endif
    return kk[255 - 32*k -: 32];
  endfunction

  task automatic push_frame(input logic [255:0] key);
    for (int k = 0; k < 8; k++) sb.push_back({(k == 7), exp_word(key, k)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [255:0] key, input bit accept);
    in_valid = 1'b1;
    in_data  = key;
    if (accept) push_frame(key);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain", {63'd0, done}, 64'd1);
  endtask

  // out_ready driver: always ready, or a 1,0,0,1 repeating pattern
  initial begin
    int cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cnt % 4 == 0) || (cnt % 4 == 3));
    end
  end

  // Monitor: handshakes pop the scoreboard; stalled words must hold
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) begin
        chk("stall_data", {32'd0, out_data}, {32'd0, stall_data});
        chk("stall_last", {63'd0, out_last}, {63'd0, stall_last});
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {63'd0, (sb.size() > 0)}, 64'd1);
        if (sb.size() > 0) begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("word", {32'd0, out_data}, {32'd0, e[31:0]});
          chk("last", {63'd0, out_last}, {63'd0, e[32]});
        end
        n_hs++;
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    // Reset state
    cyc();
    cyc();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ovr", {63'd0, overrun}, 64'd0);
    chk("rst_cnt", {56'd0, frame_count}, 64'd0);
    rst = 1'b0;
    cyc();
    chk("idle_data", {32'd0, out_data}, 64'd0);

    // Basic frame, word 0 one cycle after the strobe
    hs0 = n_hs;
    send_key(K_BASIC, 1'b1);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    chk("lat_w0", {32'd0, out_data}, {32'd0, W0_BASIC});
    wait_idle();
    chk("basic_hs", n_hs - hs0, 64'd8);
    chk("basic_cnt", {56'd0, frame_count}, 64'd1);
    chk("basic_valid", {63'd0, out_valid}, 64'd0);
    chk("basic_data", {32'd0, out_data}, 64'd0);

    // Backpressure
    rdy_mode = 1;
    hs0 = n_hs;
    send_key(K_BASIC, 1'b1);
    wait_idle();
    rdy_mode = 0;
    chk("bp_hs", n_hs - hs0, 64'd8);
    chk("bp_cnt", {56'd0, frame_count}, 64'd2);

    // Overrun: drop while word 3 is on the bus
    send_key(K_BASIC, 1'b1);
    cyc(); cyc(); cyc();
    send_key(K_ONES, 1'b0);
    chk("ovr_set", {63'd0, overrun}, 64'd1);
    wait_idle();
    chk("ovr_sticky", {63'd0, overrun}, 64'd1);
    chk("ovr_cnt", {56'd0, frame_count}, 64'd3);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    chk("ovr_clr", {63'd0, overrun}, 64'd0);

    // Clear and drop in the same cycle: set wins
    send_key(K_BASIC, 1'b1);
    in_valid = 1'b1;
    in_data = K_ONES;
    clr_overrun = 1'b1;
    cyc();
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_setwins", {63'd0, overrun}, 64'd1);
    wait_idle();
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    chk("ovr_clr2", {63'd0, overrun}, 64'd0);

    // Back-to-back: second key on the word-7 handshake
    hs0 = n_hs;
    send_key(K_BASIC, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("b2b_vld", {63'd0, out_valid}, 64'd1);
      cyc();
    end
    send_key(K_ONES, 1'b1);
    chk("b2b_vld_new", {63'd0, out_valid}, 64'd1);
    chk("b2b_w0_new", {32'd0, out_data}, {32'd0, exp_word(K_ONES, 0)});
    wait_idle();
    chk("b2b_hs", n_hs - hs0, 64'd16);
    chk("b2b_cnt", {56'd0, frame_count}, 64'd6);
    chk("b2b_ovr", {63'd0, overrun}, 64'd0);

    // Reset while word 4 is presented
    send_key(K_BASIC, 1'b1);
    cyc(); cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_data", {32'd0, out_data}, 64'd0);
    chk("mrst_last", {63'd0, out_last}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_cnt", {56'd0, frame_count}, 64'd0);
    sb.delete();
    rst = 1'b0;
    cyc();
    chk("mrst_idle", {63'd0, out_valid}, 64'd0);
    hs0 = n_hs;
    send_key(K_BASIC, 1'b1);
    chk("mrst_w0", {32'd0, out_data}, {32'd0, W0_BASIC});
    wait_idle();
    chk("mrst_hs", n_hs - hs0, 64'd8);
    chk("mrst_cnt2", {56'd0, frame_count}, 64'd1);

    // Counter wrap with random keys
    for (int f = 0; f < 255; f++) begin
      send_key({$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_idle();
      if (f == 253) chk("cnt_255", {56'd0, frame_count}, 64'd255);
    end
    chk("cnt_wrap", {56'd0, frame_count}, 64'd0);
    chk("end_ovr", {63'd0, overrun}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ed25519_pubkey_reader.md
Name: ed25519_pubkey_reader

Overview:
- Receiving end of the key-generation result interface.
- Captures the one-cycle `valid`/256-bit public-key result pulse from the Ed25519 top level.
- Streams the captured key out as fixed-width words over a valid/ready handshake to the host-side bus.
- Flags results that arrive while a previous key is still being drained.

Parameters:
- DATA_W, 256: width of the captured result; must be an integer multiple of WORD_W.
- WORD_W, 32: output word width.
- NUM_WORDS, DATA_W/WORD_W (derived, not overridable): words per frame; must be ≥ 2.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle result strobe from the key-generation top level.
- in_data  in  DATA_W  public key; sampled only when in_valid=1.
- out_valid  out  1  word available on out_data.
- out_data  out  WORD_W  current word.
- out_last  out  1  high with the final word of a frame.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- busy  out  1  frame in progress (state SEND).
- overrun  out  1  sticky: a result was dropped.
- clr_overrun  in  1  clears overrun.
- frame_count  out  CNT_W  completed frames, wraps 2^CNT_W-1 → 0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. All outputs are 0: out_valid, out_data, out_last, busy, overrun, frame_count. Reset mid-frame abandons the frame; no partial word is emitted after reset.
- States: IDLE, SEND.
- IDLE, in_valid=1:
  - Latch in_data into the shift register; word index idx=0.
  - Next cycle: state=SEND, out_valid=1, busy=1.
  - Latency: strobe at cycle N → word 0 valid at cycle N+1.
- IDLE, in_valid=0: outputs hold 0; out_data=0.
- SEND word order:
  - MSW first: word k = captured bits [DATA_W-1-k*WORD_W -: WORD_W].
  - out_last=1 only when idx=NUM_WORDS-1.
- SEND handshake:
  - out_data, out_last and out_valid are registered and stable while out_valid && !out_ready.
  - Handshake with idx<NUM_WORDS-1 → idx+1, next word presented the following cycle.
  - With out_ready held high: one word per cycle; frame = NUM_WORDS cycles.
- Final handshake (idx=NUM_WORDS-1):
  - frame_count increments.
  - If in_valid=0 that cycle: return to IDLE; out_valid, out_last, busy and out_data go 0 the next cycle.
  - If in_valid=1 that same cycle: the new key is captured, idx=0, state stays SEND, and word 0 of the new frame is presented the next cycle (no bubble, no overrun).
- in_valid=1 in SEND at any other cycle (including the final-word cycle without handshake):
  - in_data is dropped; overrun←1; the current frame continues unaffected.
- overrun: clr_overrun=1 clears it. If clr_overrun and a drop occur in the same cycle, set wins.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: ED25519_RDR_LE_BYTES_EN.
- Defined: the captured key is byte-reversed on capture (byte 0 ↔ byte DATA_W/8-1) before serialization, so words carry the RFC 8032 little-endian encoding. Word 0 holds the original bytes 0..3, with original byte 0 in out_data[31:24].
- Undefined: no reordering; serialization exactly as above.
- Handshake, timing, counter and overrun behaviour are identical in both builds.

Test Plan:
- Basic frame: reset, in_valid pulse with in_data=256'h0001020304…1F, out_ready=1.
  - Words 32'h00010203, 32'h04050607, …, 32'h1C1D1E1F on consecutive cycles starting N+1.
  - out_last only on word 7; frame_count=1; busy low after.
- Backpressure: same key, out_ready toggled 1,0,0,1,…
  - out_data/out_last stable during stall cycles; no word skipped or duplicated.
  - Exactly 8 handshakes, then frame_count=1.
- Overrun: second in_valid (key 256'hFF..FF) at word 3 of first frame.
  - First frame completes intact; overrun=1; no second frame; frame_count=1.
  - clr_overrun pulse → overrun=0.
  - clr_overrun asserted in the same cycle as a new drop → overrun stays 1.
- Back-to-back: new in_valid coincident with word-7 handshake.
  - Word 0 of the new key on the next cycle with out_valid continuously high.
  - 16 total words; frame_count=2; overrun=0.
- Reset mid-frame: rst at word 4.
  - Next cycle all outputs 0, state IDLE.
  - A fresh in_valid afterward produces a full 8-word frame from word 0.
- Wrap and byte order: 256 frames → frame_count=0.
  - With ED25519_RDR_LE_BYTES_EN defined and in_data=256'h0001…1F: first word 32'h1F1E1D1C.
